// File: rtl/npu_stream_pkg.sv
// Shared helpers for the NPU stream width converters: default beat width,
// lane-count to lane-mask conversion and the output-side ready equation.
package npu_stream_pkg;

    localparam int unsigned DEFAULT_BEAT_W = 8;

    // Lane mask with the low 'count' bits set; supports up to 32 lanes.
    function automatic logic [31:0] count_to_mask(input int unsigned count);
        logic [63:0] wide;
        wide = (64'(1) << count) - 64'(1);
        return 32'(wide);
    endfunction

    // Upstream may push whenever the output slot is empty or draining now.
    function automatic logic out_hs_ready(input logic out_valid, input logic out_ready);
        return !out_valid || out_ready;
    endfunction

endpackage

// File: rtl/stream_packer.sv
// Width-up converter: packs RATIO narrow beats into one wide word, lane 0 in
// the LSBs. A last beat flushes a partial word, zero-padded, with its lane
// count. Optional macro STREAM_PACKER_MASK_EN adds a registered lane mask.
module stream_packer
    import npu_stream_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DEFAULT_BEAT_W,
    parameter int unsigned RATIO    = 4
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    output logic                                o_input_ready,
    input  logic                                i_input_valid,
    input  logic [IN_WIDTH-1:0]                 i_input_data,
    input  logic                                i_input_last,
    input  logic                                i_output_ready,
    output logic                                o_output_valid,
    output logic [IN_WIDTH*RATIO-1:0]           o_output_data,
    output logic                                o_output_last,
`ifdef STREAM_PACKER_MASK_EN
    output logic [RATIO-1:0]                    o_output_mask,
`endif
    output logic [$clog2(RATIO+1)-1:0]          o_output_count
);

    localparam int unsigned OUT_WIDTH    = IN_WIDTH * RATIO;
    localparam int unsigned CNT_BIT      = $clog2(RATIO);
    localparam int unsigned LANE_OCP_BIT = $clog2(RATIO + 1);

    logic [CNT_BIT-1:0]      lane_cnt;
    logic [OUT_WIDTH-1:0]    asm_data;
    logic [OUT_WIDTH-1:0]    asm_next;
    logic [OUT_WIDTH-1:0]    packed_word;
    logic [OUT_WIDTH-1:0]    out_data;
    logic                    out_last;
    logic [LANE_OCP_BIT-1:0] out_count;
    logic                    out_valid;
    logic                    in_en;
    logic                    out_en;
    logic                    word_done;

    assign o_input_ready = out_hs_ready(out_valid, i_output_ready);
    assign in_en         = o_input_ready && i_input_valid;
    assign out_en        = i_output_ready && out_valid;
    assign word_done     = in_en && ((lane_cnt == CNT_BIT'(RATIO - 1)) || i_input_last);

    // Per-lane insert of the incoming beat and zero-padding above it.
    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        localparam int unsigned LO = g * IN_WIDTH;
        assign asm_next[LO +: IN_WIDTH] =
            (CNT_BIT'(g) == lane_cnt) ? i_input_data : asm_data[LO +: IN_WIDTH];
        assign packed_word[LO +: IN_WIDTH] =
            (CNT_BIT'(g) <  lane_cnt) ? asm_data[LO +: IN_WIDTH] :
            (CNT_BIT'(g) == lane_cnt) ? i_input_data : '0;
    end

    // Lane pointer: advance per accepted beat, wrap when a word closes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lane_cnt <= '0;
        end else if (in_en) begin
            lane_cnt <= word_done ? '0 : lane_cnt + CNT_BIT'(1);
        end
    end

    // Assembly buffer; stale lanes are masked by zero-padding, so no reset.
    always_ff @(posedge i_clk) begin
        if (in_en && !word_done) begin
            asm_data <= asm_next;
        end
    end

    // Output slot: load on a completing beat, drop when drained.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_count <= '0;
        end else if (word_done) begin
            out_valid <= 1'b1;
            out_data  <= packed_word;
            out_last  <= i_input_last;
            out_count <= LANE_OCP_BIT'(lane_cnt) + LANE_OCP_BIT'(1);
        end else if (out_en) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_PACKER_MASK_EN
    logic [RATIO-1:0] out_mask;

    // Lane mask registered alongside the word it describes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            out_mask <= '0;
        end else if (word_done) begin
            out_mask <= RATIO'(count_to_mask(32'(lane_cnt) + 32'd1));
        end
    end

    assign o_output_mask = out_mask;
`endif

    assign o_output_valid = out_valid;
    assign o_output_data  = out_data;
    assign o_output_last  = out_last;
    assign o_output_count = out_count;

endmodule

// File: tb/tb_stream_packer.sv
// Directed self-checking bench for stream_packer (IN_WIDTH=8, RATIO=4).
module tb_stream_packer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_input_ready;
    logic        i_input_valid;
    logic [7:0]  i_input_data;
    logic        i_input_last;
    logic        i_output_ready;
    logic        o_output_valid;
    logic [31:0] o_output_data;
    logic        o_output_last;
    logic [2:0]  o_output_count;
`ifdef STREAM_PACKER_MASK_EN
    logic [3:0]  o_output_mask;
`endif

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    stream_packer #(.IN_WIDTH(8), .RATIO(4)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_input_ready  (o_input_ready),
        .i_input_valid  (i_input_valid),
        .i_input_data   (i_input_data),
        .i_input_last   (i_input_last),
        .i_output_ready (i_output_ready),
        .o_output_valid (o_output_valid),
        .o_output_data  (o_output_data),
        .o_output_last  (o_output_last),
`ifdef STREAM_PACKER_MASK_EN
        .o_output_mask  (o_output_mask),
`endif
        .o_output_count (o_output_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        i_input_valid = v;
        i_input_data  = d;
        i_input_last  = l;
    endtask

    task automatic check_word(input string tag, input logic [31:0] d, input logic [2:0] c,
                              input logic l, input logic [3:0] m);
        check({tag, "_valid"}, 64'(o_output_valid), 64'(1));
        check({tag, "_data"},  64'(o_output_data),  64'(d));
        check({tag, "_count"}, 64'(o_output_count), 64'(c));
        check({tag, "_last"},  64'(o_output_last),  64'(l));
`ifdef STREAM_PACKER_MASK_EN
        check({tag, "_mask"},  64'(o_output_mask),  64'(m));
`else
        if (m == 4'hx) $display("unreachable");
`endif
    endtask

    initial begin
        i_reset = 1'b1;
        i_output_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        i_reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(o_output_valid), 64'(0));
        check("rst_data",  64'(o_output_data),  64'(0));
        check("rst_count", 64'(o_output_count), 64'(0));
        check("rst_last",  64'(o_output_last),  64'(0));
        check("rst_ready", 64'(o_input_ready),  64'(1));
`ifdef STREAM_PACKER_MASK_EN
        check("rst_mask",  64'(o_output_mask),  64'(0));
`endif

        // Full word
        i_output_ready = 1'b1;
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        check("full_early_valid", 64'(o_output_valid), 64'(0));
        drive(1'b1, 8'h44, 1'b0); tick();
        check_word("full", 32'h44332211, 3'd4, 1'b0, 4'b1111);
        drive(1'b0, 8'h00, 1'b0); tick();
        check("full_drain_valid", 64'(o_output_valid), 64'(0));

        // Partial flush then single-beat flush landing in lane 0
        drive(1'b1, 8'hAA, 1'b0); tick();
        drive(1'b1, 8'hBB, 1'b1); tick();
        check_word("partial", 32'h0000BBAA, 3'd2, 1'b1, 4'b0011);
        drive(1'b1, 8'h5C, 1'b1); tick();
        check_word("single", 32'h0000005C, 3'd1, 1'b1, 4'b0001);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Invalid beats ignored; full word closed by last on lane 3
        drive(1'b1, 8'hC1, 1'b0); tick();
        drive(1'b0, 8'hFF, 1'b1); tick();
        drive(1'b1, 8'hC2, 1'b0); tick();
        drive(1'b1, 8'hC3, 1'b0); tick();
        drive(1'b1, 8'hC4, 1'b1); tick();
        check_word("fulllast", 32'hC4C3C2C1, 3'd4, 1'b1, 4'b1111);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Backpressure: word held, input stalled, then resume without loss
        i_output_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        drive(1'b1, 8'h44, 1'b0); tick();
        drive(1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(o_input_ready), 64'(0));
            tick();
            check_word("bp_hold", 32'h44332211, 3'd4, 1'b0, 4'b1111);
        end
        i_output_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(o_input_ready), 64'(1));
        tick();
        check("bp_drain_valid", 64'(o_output_valid), 64'(0));
        drive(1'b1, 8'h66, 1'b0); tick();
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b1, 8'h88, 1'b0); tick();
        check_word("bp_next", 32'h88776655, 3'd4, 1'b0, 4'b1111);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Reset mid-word, with a beat offered during reset
        drive(1'b1, 8'h01, 1'b0); tick();
        drive(1'b1, 8'h02, 1'b0); tick();
        i_reset = 1'b1;
        drive(1'b1, 8'h03, 1'b0); tick();
        i_reset = 1'b0;
        check("rstmid_valid", 64'(o_output_valid), 64'(0));
        check("rstmid_ready", 64'(o_input_ready),  64'(1));
        drive(1'b1, 8'hA0, 1'b0); tick();
        check("rstmid_v0", 64'(o_output_valid), 64'(0));
        drive(1'b1, 8'hA1, 1'b0); tick();
        check("rstmid_v1", 64'(o_output_valid), 64'(0));
        drive(1'b1, 8'hA2, 1'b0); tick();
        check("rstmid_v2", 64'(o_output_valid), 64'(0));
        drive(1'b1, 8'hA3, 1'b0); tick();
        check_word("rstmid", 32'hA3A2A1A0, 3'd4, 1'b0, 4'b1111);
        drive(1'b0, 8'h00, 1'b0); tick();

        // Streaming: one beat per cycle, back-to-back words
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            check("stream_ready", 64'(o_input_ready), 64'(1));
            tick();
            if ((i % 4) == 3) begin
                check_word("stream",
                           {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)},
                           3'd4, 1'b0, 4'b1111);
            end else begin
                check("stream_gap_valid", 64'(o_output_valid), 64'(0));
            end
        end
        drive(1'b0, 8'h00, 1'b0); tick();
        check("end_valid", 64'(o_output_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
